// File: rtl/demux_1x4_pkg.sv
// rtl/demux_1x4_pkg.sv - shared channel count, select type and one-hot decode for demux_1x4
package demux_1x4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [3:0] onehot4(input sel_t sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux_1x4_if.sv
// rtl/demux_1x4_if.sv - routing bus between a demux_1x4 driver (master) and the demux (slave)
interface demux_1x4_if
  import demux_1x4_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
);

  logic [DATA_W-1:0]        in;
  sel_t                     a;
  logic                     en;
  logic                     clr;
  logic [NUM_CH*DATA_W-1:0] y;
  logic [NUM_CH*DATA_W-1:0] y_q;
  logic [NUM_CH-1:0]        y_vld;
  logic [NUM_CH*CNT_W-1:0]  cnt;

  modport master (
    output in, a, en, clr,
    input  y, y_q, y_vld, cnt
  );

  modport slave (
    input  in, a, en, clr,
    output y, y_q, y_vld, cnt
  );

endinterface

// File: rtl/demux_1x4_chan_cnt.sv
// rtl/demux_1x4_chan_cnt.sv - per-channel saturating route counter; clr beats inc
module demux_1x4_chan_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/demux_1x4.sv
// rtl/demux_1x4.sv - 1:4 demux with combinational and registered outputs plus one-hot valid
// Define DEMUX_1X4_STATS_EN to build the per-channel saturating route counters.
module demux_1x4
  import demux_1x4_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  demux_1x4_if.slave   bus
);

  logic [NUM_CH-1:0]        w_hot;
  logic [NUM_CH*DATA_W-1:0] w_y;
  logic [NUM_CH*CNT_W-1:0]  w_cnt;
  logic [NUM_CH*DATA_W-1:0] r_y_q;
  logic [NUM_CH-1:0]        r_y_vld;

  // The one-hot select gates both the data slices and the valid, so they cannot disagree.
  assign w_hot = bus.en ? onehot4(bus.a) : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
    assign w_y[k*DATA_W +: DATA_W] = w_hot[k] ? bus.in : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q   <= '0;
      r_y_vld <= '0;
    end else begin
      r_y_q   <= w_y;
      r_y_vld <= w_hot;
    end
  end

`ifdef DEMUX_1X4_STATS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    demux_1x4_chan_cnt #(
      .CNT_W (CNT_W)
    ) u_chan_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_hot[k]),
      .clr (bus.clr),
      .cnt (w_cnt[k*CNT_W +: CNT_W])
    );
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clr;
  assign w_cnt        = '0;
`endif

  assign bus.y     = w_y;
  assign bus.y_q   = r_y_q;
  assign bus.y_vld = r_y_vld;
  assign bus.cnt   = w_cnt;

  a_sel_known : assert property (@(posedge clk) disable iff (rst)
    bus.en |-> !$isunknown(bus.a));
  a_en_known : assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.en));

endmodule

// File: tb/tb_demux_1x4.sv
// tb/tb_demux_1x4.sv - directed and random checks of demux_1x4 (DATA_W=1 and DATA_W=8) against a reference model
module tb_demux_1x4;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef DEMUX_1X4_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;

  demux_1x4_if #(.DATA_W(1), .CNT_W(CW)) if1 ();
  demux_1x4_if #(.DATA_W(8), .CNT_W(CW)) if8 ();

  demux_1x4 #(.DATA_W(1), .CNT_W(CW)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  demux_1x4 #(.DATA_W(8), .CNT_W(CW)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] m_yq1;
  logic [31:0] m_yq8;
  logic [3:0]  m_vld;
  int          m_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected output word: the masked data shifted to channel sel's slice, or zero.
  function automatic logic [31:0] exp_y(input int dw, input logic [7:0] d,
                                        input logic [1:0] sel, input logic e);
    logic [31:0] v;
    v = 32'(d) & ((32'd1 << dw) - 32'd1);
    return e ? (v << (int'(sel) * dw)) : 32'd0;
  endfunction

  task automatic model_reset();
    m_yq1 = '0;
    m_yq8 = '0;
    m_vld = '0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":y_q1"}, 32'(if1.y_q), m_yq1);
    chk({tag, ":y_q8"}, 32'(if8.y_q), m_yq8);
    chk({tag, ":vld1"}, 32'(if1.y_vld), 32'(m_vld));
    chk({tag, ":vld8"}, 32'(if8.y_vld), 32'(m_vld));
    chk({tag, ":onehot0"}, 32'($onehot0(if8.y_vld)), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk({tag, ":cnt1"}, 32'(if1.cnt[k*CW +: CW]), 32'(m_cnt[k]));
      chk({tag, ":cnt8"}, 32'(if8.cnt[k*CW +: CW]), 32'(m_cnt[k]));
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] sel, input logic e, input logic c);
    if1.in  = d[0];
    if8.in  = d;
    if1.a   = sel;
    if8.a   = sel;
    if1.en  = e;
    if8.en  = e;
    if1.clr = c;
    if8.clr = c;
  endtask

  // Apply inputs, check the combinational path, take one edge, check the registered path.
  task automatic step(input string tag, input logic [7:0] d, input logic [1:0] sel,
                      input logic e, input logic c);
    drive(d, sel, e, c);
    #1;
    chk({tag, ":y1"}, 32'(if1.y), exp_y(1, d, sel, e));
    chk({tag, ":y8"}, 32'(if8.y), exp_y(8, d, sel, e));
    @(posedge clk);
    m_yq1 = exp_y(1, d, sel, e);
    m_yq8 = exp_y(8, d, sel, e);
    m_vld = e ? (4'b0001 << sel) : 4'b0000;
    if (STATS) begin
      if (c) begin
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (e) begin
        m_cnt[sel] = (m_cnt[sel] < CNT_MAX) ? m_cnt[sel] + 1 : CNT_MAX;
      end
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 2'd0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_regs("reset");
    drive(8'h01, 2'd2, 1'b1, 1'b0);
    #1;
    chk("y_in_reset", 32'(if1.y), 32'h4);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_yq1 = 32'h4;
    m_yq8 = 32'h0001_0000;
    m_vld = 4'b0100;
    if (STATS) m_cnt[2] = 1;
    check_regs("first_edge");

    for (int i = 0; i < 4; i++) begin
      step("sweep", 8'h01, 2'(i), 1'b1, 1'b0);
      chk("sweep_lit", 32'(if1.y_q), 32'(4'b0001 << i));
    end

    step("a5_off", 8'hA5, 2'd2, 1'b0, 1'b0);
    step("a5_on", 8'hA5, 2'd2, 1'b1, 1'b0);
    chk("a5_lit", 32'(if8.y), 32'h00A5_0000);
    step("zero_data", 8'h00, 2'd1, 1'b1, 1'b0);
    chk("zero_vld_lit", 32'(if8.y_vld), 32'h2);

    step("clr_all", 8'h00, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("cnt0_up", 8'(i), 2'd0, 1'b1, 1'b0);
    step("clr_vs_inc", 8'h3C, 2'd0, 1'b1, 1'b1);
    chk("clr_vs_inc_lit", 32'(if8.cnt[0 +: CW]), 32'd0);

    for (int i = 0; i < 20; i++) step("sat3", 8'($urandom), 2'd3, 1'b1, 1'b0);
    chk("sat3_lit", 32'(if8.cnt[3*CW +: CW]), STATS ? 32'd15 : 32'd0);

    for (int i = 0; i < 200; i++) begin
      step("rand", 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    step("pre_rst", 8'h5A, 2'd1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("async_rst");
    chk("y_during_rst", 32'(if8.y), 32'h0000_5A00);
    #2;
    rst = 1'b0;
    step("post_rst", 8'h5A, 2'd1, 1'b1, 1'b0);
    chk("post_rst_lit", 32'(if1.y_vld), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
